spi_dac_ctrl: RTL

Parametrised SPI master for serial-input voltage-output DACs (AD5541-class and wider), driving NUM_CH devices on a shared SCLK/MOSI bus with one active-low chip select per device. It accepts one word per valid/ready handshake, shifts it out MSB first, and generates LDAC either after every frame or once after a group of frames. SCLK is derived from the system clock by an enable-tick divider. The block sits between the control datapath and the DAC pins.

---
 rtl/spi_dac_pkg.sv | 23 ++
 rtl/spi_dac_ctrl_if.sv | 21 ++
 rtl/spi_clk_gen.sv | 30 +++
 rtl/spi_dac_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/spi_dac_pkg.sv
// Shared types and constants for the SPI DAC controller.
package spi_dac_pkg;

    // Controller sequencing: shift a frame, hold csn, enforce CS-high time,
    // then optionally strobe LDAC.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_TAIL,
        ST_GAP,
        ST_LDAC
    } state_t;

    // LDAC_MODE encodings
    localparam int LDAC_PER_FRAME = 0;
    localparam int LDAC_ON_LAST   = 1;

    // Width of the channel select field; a single device still gets one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_dac_ctrl_if.sv
// Word handshake between the control datapath and the SPI DAC controller.
interface spi_dac_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int CH_W   = 1
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CH_W-1:0]   in_ch;
    logic              in_last;

    modport master (
        output in_valid, in_data, in_ch, in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_data, in_ch, in_last,
        output in_ready
    );
endinterface

// File: rtl/spi_clk_gen.sv
// Half-period tick generator: one tick every CLK_DIV clk cycles while not
// cleared. The controller toggles sclk and advances phases on these ticks,
// so no derived clock ever exists.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    output logic tick
);
    localparam int                CNT_W = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0]  TERM  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Count up to the terminal value and restart; held at zero while cleared
    // so the first phase after leaving idle is a full CLK_DIV cycles.
    always_ff @(posedge clk) begin
        if (!resetn || clear)
            cnt <= '0;
        else if (cnt == TERM)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = !clear && (cnt == TERM);

endmodule

// File: rtl/spi_dac_ctrl.sv
// SPI master for serial-input DACs: one word per handshake, MSB first,
// per-device active-low chip select, LDAC after each frame or after a
// tagged group. Outputs are decoded from registered state only.
module spi_dac_ctrl
    import spi_dac_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int CLK_DIV   = 4,
    parameter int NUM_CH    = 1,
    parameter int LDAC_MODE = LDAC_PER_FRAME
) (
    input  logic              clk,
    input  logic              resetn,
    spi_dac_ctrl_if.slave     bus,
    output logic              sclk,
    output logic              mosi,
    output logic [NUM_CH-1:0] csn,
    output logic              ldac_n,
    output logic              busy,
    output logic              err
);
    localparam int               CH_W     = ch_width(NUM_CH);
    localparam int               BIT_W    = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg;
    logic [CH_W-1:0]   ch_q;
    logic              last_q;
    logic              sclk_q;
    logic              err_q;
    logic [BIT_W-1:0]  bit_cnt;
    logic              tick;
    logic              idle;
    logic              accept;
    logic              ch_ok;
    logic              frame_act;
    logic              ldac_wanted;

    assign idle        = (state_q == ST_IDLE);
    assign accept      = bus.in_valid && idle;
    assign ch_ok       = int'(bus.in_ch) < NUM_CH;
    assign frame_act   = (state_q == ST_SHIFT) || (state_q == ST_TAIL);
    assign ldac_wanted = (LDAC_MODE == LDAC_PER_FRAME) ||
                         ((LDAC_MODE == LDAC_ON_LAST) && last_q);

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk    (clk),
        .resetn (resetn),
        .clear  (idle),
        .tick   (tick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state: every non-idle phase lasts a whole number of ticks; SHIFT
    // ends on the falling half-period of the last bit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept && ch_ok)                        state_d = ST_SHIFT;
            ST_SHIFT: if (tick && sclk_q && bit_cnt == LAST_BIT)  state_d = ST_TAIL;
            ST_TAIL:  if (tick)                                   state_d = ST_GAP;
            ST_GAP:   if (tick) state_d = ldac_wanted ? ST_LDAC : ST_IDLE;
            ST_LDAC:  if (tick)                                   state_d = ST_IDLE;
            default:                                              state_d = ST_IDLE;
        endcase
    end

    // Datapath: latch the word on accept, then toggle sclk on each tick and
    // shift on the falling half so mosi changes at the start of a low phase.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            shreg   <= '0;
            ch_q    <= '0;
            last_q  <= 1'b0;
            bit_cnt <= '0;
            sclk_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= accept && !ch_ok;
            if (accept && ch_ok) begin
                shreg   <= bus.in_data;
                ch_q    <= bus.in_ch;
                last_q  <= bus.in_last;
                bit_cnt <= '0;
                sclk_q  <= 1'b0;
            end else if (state_q == ST_SHIFT && tick) begin
                if (!sclk_q) begin
                    sclk_q <= 1'b1;
                end else begin
                    sclk_q <= 1'b0;
                    // Final bit keeps its value on mosi through TAIL.
                    if (bit_cnt != LAST_BIT) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        shreg   <= {shreg[DATA_W-2:0], 1'b0};
                    end
                end
            end
        end
    end

    // One chip select per device, low only while its frame is on the wire.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_csn
        assign csn[i] = ~(frame_act && (ch_q == CH_W'(i)));
    end

    assign mosi         = frame_act && shreg[DATA_W-1];
    assign sclk         = sclk_q;
    assign ldac_n       = (state_q != ST_LDAC);
    assign bus.in_ready = idle;
    assign busy         = !idle;
    assign err          = err_q;

endmodule
